// File: rtl/bus_xfer_seq.sv
// ---------------------------------------------------------------------------
// bus_xfer_seq -- initiator for the shared 1-bit register bus.
//
// Accepts one register-transfer command at a time and expands it into 1-3
// bus cycles. It generates the load (r_in) and drive (r_out) strobes for the
// bus-attached register cells, and the strobes for a temp register and an
// external bus driver. At most one driver and one loader are active per
// cycle.
//
// Handshake: a command transfers on the rising edge where
// cmd_valid && cmd_ready. cmd_ready is high only in IDLE and depends on
// state alone. op/src/dst are captured on that edge. The inputs are then
// ignored until the sequencer returns to IDLE. cmd_valid may stay high.
//
// Ports:
//   clk        system clock, rising-edge active
//   reset      synchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  sequencer idle and able to accept
//   cmd_op     00 MOV, 01 SWAP, 10 LOAD (external -> dst), 11 NOP
//   cmd_src    source register index
//   cmd_dst    destination register index
//   r_in       per-register load strobe (one-hot or zero)
//   r_out      per-register bus-drive enable (one-hot or zero)
//   tmp_in     temp register load strobe
//   tmp_out    temp register bus-drive enable
//   ext_out    external source bus-drive enable
//   done       final step of the current command
//   err        with done: command rejected (index out of range)
//   dbg_state  current FSM state (0 IDLE, 1 S1, 2 S2, 3 S3)
// ---------------------------------------------------------------------------
module bus_xfer_seq #(
    parameter int NREG = 8,
    parameter int SELW = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [SELW-1:0] cmd_src,
    input  logic [SELW-1:0] cmd_dst,
    output logic [NREG-1:0] r_in,
    output logic [NREG-1:0] r_out,
    output logic            tmp_in,
    output logic            tmp_out,
    output logic            ext_out,
    output logic            done,
    output logic            err,
    output logic [1:0]      dbg_state
);

    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_SWAP = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    // One extra bit so the compare also works when NREG == 2**SELW.
    localparam logic [SELW:0] NREG_LIM = (SELW+1)'(NREG);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_S1   = 2'd1,
        ST_S2   = 2'd2,
        ST_S3   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [SELW-1:0] src_q, src_d;
    logic [SELW-1:0] dst_q, dst_d;

    logic src_bad, dst_bad, uses_src, uses_dst, cmd_err, same_idx;

    function automatic logic [NREG-1:0] onehot(input logic [SELW-1:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) begin
            v[i] = (idx == SELW'(i));
        end
        return v;
    endfunction

    // All decode works on the captured command, so the strobes never carry
    // a combinational path from the cmd_* inputs.
    always_comb begin
        src_bad  = ({1'b0, src_q} >= NREG_LIM);
        dst_bad  = ({1'b0, dst_q} >= NREG_LIM);
        uses_src = (op_q == OP_MOV) || (op_q == OP_SWAP);
        uses_dst = (op_q != OP_NOP);
        // The range check takes priority over the src==dst shortcut.
        cmd_err  = (uses_src && src_bad) || (uses_dst && dst_bad);
        same_idx = uses_src && (src_q == dst_q);
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cmd_ready = 1'b0;
        r_in      = '0;
        r_out     = '0;
        tmp_in    = 1'b0;
        tmp_out   = 1'b0;
        ext_out   = 1'b0;
        done      = 1'b0;
        err       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    src_d   = cmd_src;
                    dst_d   = cmd_dst;
                    state_d = ST_S1;
                end
            end
            ST_S1: begin
                if (cmd_err) begin
                    done    = 1'b1;
                    err     = 1'b1;
                    state_d = ST_IDLE;
                end else if (op_q == OP_SWAP && !same_idx) begin
                    // SWAP step 1: park src in the temp register.
                    r_out   = onehot(src_q);
                    tmp_in  = 1'b1;
                    state_d = ST_S2;
                end else begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                    if (op_q == OP_MOV && !same_idx) begin
                        r_out = onehot(src_q);
                        r_in  = onehot(dst_q);
                    end else if (op_q == OP_LOAD) begin
                        ext_out = 1'b1;
                        r_in    = onehot(dst_q);
                    end
                end
            end
            ST_S2: begin
                // SWAP step 2: dst overwrites src.
                r_out   = onehot(dst_q);
                r_in    = onehot(src_q);
                state_d = ST_S3;
            end
            ST_S3: begin
                // SWAP step 3: the saved src value goes into dst.
                tmp_out = 1'b1;
                r_in    = onehot(dst_q);
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            src_q   <= '0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_xfer_seq.sv
// ---------------------------------------------------------------------------
// tb_bus_xfer_seq -- self-checking bench for bus_xfer_seq.
// Two instances share one command stream: NREG=8 and NREG=6 (SELW=3), so
// that out-of-range indices can be exercised. A small bus model (register
// bits, temp, external bit) follows the NREG=8 strobes. Its contents are
// compared against the intended effect of each command.
// ---------------------------------------------------------------------------
module tb_bus_xfer_seq;

    localparam int REC_W = 22;   // {r_in[8], r_out[8], ti, to, eo, done, err, ready}
    typedef logic [REC_W-1:0] rec_t;
    localparam rec_t IDLE_REC = 22'h000001;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [2:0] cmd_src, cmd_dst;

    logic [7:0] r_in8, r_out8;
    logic       tmp_in8, tmp_out8, ext_out8, done8, err8, cmd_ready8;
    logic [1:0] dbg8;
    logic [5:0] r_in6, r_out6;
    logic       tmp_in6, tmp_out6, ext_out6, done6, err6, cmd_ready6;
    logic [1:0] dbg6;

    bus_xfer_seq #(.NREG(8), .SELW(3)) dut8 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready8),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
        .r_in(r_in8), .r_out(r_out8), .tmp_in(tmp_in8), .tmp_out(tmp_out8),
        .ext_out(ext_out8), .done(done8), .err(err8), .dbg_state(dbg8)
    );

    bus_xfer_seq #(.NREG(6), .SELW(3)) dut6 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready6),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
        .r_in(r_in6), .r_out(r_out6), .tmp_in(tmp_in6), .tmp_out(tmp_out6),
        .ext_out(ext_out6), .done(done6), .err(err6), .dbg_state(dbg6)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [2*REC_W-1:0] exp_q[$];
    logic started = 1'b0;

    logic [7:0] breg;    // bus model: register bits seen by dut8's strobes
    logic [7:0] mreg;    // intended register contents
    logic       tmp_v = 1'b0;
    logic       ext_v = 1'b0;

    typedef struct {
        logic [1:0] op;
        int         src;
        int         dst;
        int         n;
        rec_t       s0, s1, s2;
    } vec_t;
    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic rec_t mk(input logic [7:0] rin, input logic [7:0] rout, input logic [4:0] f);
        return {rin, rout, f, 1'b0};   // f = {tmp_in, tmp_out, ext_out, done, err}
    endfunction

    function automatic logic [7:0] oh(input int i);
        logic [7:0] one;
        one = 8'd1;
        return one << i;
    endfunction

    // Steps a command should produce on a sequencer with nreg registers.
    function automatic int model(input int nreg, input logic [1:0] op, input int src,
                                 input int dst, output logic [3*REC_W-1:0] st);
        logic bad_idx;
        st = '0;
        case (op)
            2'd0, 2'd1: bad_idx = (src >= nreg) || (dst >= nreg);
            2'd2:       bad_idx = (dst >= nreg);
            default:    bad_idx = 1'b0;
        endcase
        if (bad_idx) begin
            st[0 +: REC_W] = mk(8'h00, 8'h00, 5'b00011);
            return 1;
        end
        if (op == 2'd3 || (op != 2'd2 && src == dst)) begin
            st[0 +: REC_W] = mk(8'h00, 8'h00, 5'b00010);
            return 1;
        end
        if (op == 2'd0) begin
            st[0 +: REC_W] = mk(oh(dst), oh(src), 5'b00010);
            return 1;
        end
        if (op == 2'd2) begin
            st[0 +: REC_W] = mk(oh(dst), 8'h00, 5'b00110);
            return 1;
        end
        st[0       +: REC_W] = mk(8'h00,   oh(src), 5'b10000);
        st[REC_W   +: REC_W] = mk(oh(src), oh(dst), 5'b00000);
        st[2*REC_W +: REC_W] = mk(oh(dst), 8'h00,   5'b01010);
        return 3;
    endfunction

    function automatic logic [2*REC_W-1:0] actual();
        rec_t a8, a6;
        a8 = {r_in8, r_out8, tmp_in8, tmp_out8, ext_out8, done8, err8, cmd_ready8};
        a6 = {2'b00, r_in6, 2'b00, r_out6, tmp_in6, tmp_out6, ext_out6, done6, err6, cmd_ready6};
        return {a8, a6};
    endfunction

    // ---------------- bus model and invariants ----------------
    always @(posedge clk) begin
        logic bus;
        bus = |(r_out8 & breg) | (tmp_out8 & tmp_v) | (ext_out8 & ext_v);
        for (int i = 0; i < 8; i++) begin
            if (r_in8[i] === 1'b1) breg[i] <= bus;
        end
        if (tmp_in8 === 1'b1) tmp_v <= bus;
    end

    always @(negedge clk) begin
        int o8, i8, o6, i6;
        logic ok8, ok6;
        if (started) begin
            o8 = $countones(r_out8) + int'(tmp_out8) + int'(ext_out8);
            i8 = $countones(r_in8) + int'(tmp_in8);
            o6 = $countones(r_out6) + int'(tmp_out6) + int'(ext_out6);
            i6 = $countones(r_in6) + int'(tmp_in6);
            ok8 = (o8 <= 1) && (i8 <= 1) && (!cmd_ready8 || (o8 + i8 == 0));
            ok6 = (o6 <= 1) && (i6 <= 1) && (!cmd_ready6 || (o6 + i6 == 0));
            check("invariant8", 64'(ok8), 64'd1);
            check("invariant6", 64'(ok6), 64'd1);
        end
    end

    // ---------------- driver ----------------
    task automatic run_cmd(input logic [1:0] op, input int src, input int dst,
                           input int n8, input logic [3*REC_W-1:0] e8, input string name);
        logic [3*REC_W-1:0] e6;
        int   n6, n;
        rec_t s8, s6;
        logic t;
        n6 = model(6, op, src, dst, e6);
        n  = (n8 > n6) ? n8 : n6;
        for (int k = 0; k < n; k++) begin
            s8 = (k < n8) ? e8[k*REC_W +: REC_W] : IDLE_REC;
            s6 = (k < n6) ? e6[k*REC_W +: REC_W] : IDLE_REC;
            exp_q.push_back({s8, s6});
        end
        @(negedge clk);
        check({name, " idle"}, 64'(actual()), 64'({IDLE_REC, IDLE_REC}));
        ext_v     = 1'($urandom_range(0, 1));
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = 3'(src);
        cmd_dst   = 3'(dst);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            // Scramble the command fields: the captured command must rule.
            cmd_valid = 1'b0;
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_src   = 3'($urandom_range(0, 7));
            cmd_dst   = 3'($urandom_range(0, 7));
            check(name, 64'(actual()), 64'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
        if (op == 2'd0 && src != dst) mreg[dst] = mreg[src];
        if (op == 2'd2) mreg[dst] = ext_v;
        if (op == 2'd1 && src != dst) begin
            t         = mreg[src];
            mreg[src] = mreg[dst];
            mreg[dst] = t;
        end
        check({name, " regs"}, 64'(breg), 64'(mreg));
    endtask

    // ---------------- test ----------------
    initial begin
        logic [3*REC_W-1:0] e8, e6;
        int n8;

        vecs[0]  = '{2'd0, 2, 5, 1, mk(8'h20, 8'h04, 5'b00010), '0, '0};
        vecs[1]  = '{2'd1, 1, 6, 3, mk(8'h00, 8'h02, 5'b10000),
                     mk(8'h02, 8'h40, 5'b00000), mk(8'h40, 8'h00, 5'b01010)};
        vecs[2]  = '{2'd2, 3, 0, 1, mk(8'h01, 8'h00, 5'b00110), '0, '0};
        vecs[3]  = '{2'd3, 5, 2, 1, mk(8'h00, 8'h00, 5'b00010), '0, '0};
        vecs[4]  = '{2'd1, 3, 3, 1, mk(8'h00, 8'h00, 5'b00010), '0, '0};
        vecs[5]  = '{2'd0, 4, 4, 1, mk(8'h00, 8'h00, 5'b00010), '0, '0};
        vecs[6]  = '{2'd0, 7, 0, 1, mk(8'h01, 8'h80, 5'b00010), '0, '0};
        vecs[7]  = '{2'd1, 0, 7, 3, mk(8'h00, 8'h01, 5'b10000),
                     mk(8'h01, 8'h80, 5'b00000), mk(8'h80, 8'h00, 5'b01010)};
        vecs[8]  = '{2'd2, 1, 6, 1, mk(8'h40, 8'h00, 5'b00110), '0, '0};
        vecs[9]  = '{2'd0, 7, 7, 1, mk(8'h00, 8'h00, 5'b00010), '0, '0};
        vecs[10] = '{2'd1, 7, 2, 3, mk(8'h00, 8'h80, 5'b10000),
                     mk(8'h80, 8'h04, 5'b00000), mk(8'h04, 8'h00, 5'b01010)};

        breg      = 8'($urandom);
        mreg      = breg;
        reset     = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_src   = 3'd2;
        cmd_dst   = 3'd5;

        // Reset held with cmd_valid high: idle outputs, nothing accepted.
        repeat (2) begin
            @(negedge clk);
            started = 1'b1;
            check("reset hold", 64'(actual()), 64'({IDLE_REC, IDLE_REC}));
        end
        reset     = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("reset release", 64'(actual()), 64'({IDLE_REC, IDLE_REC}));
        check("reset regs", 64'(breg), 64'(mreg));

        // Directed vectors.
        for (int i = 0; i < 11; i++) begin
            run_cmd(vecs[i].op, vecs[i].src, vecs[i].dst, vecs[i].n,
                    {vecs[i].s2, vecs[i].s1, vecs[i].s0}, $sformatf("vec%0d", i));
        end

        // cmd_valid held high during the busy step must not start a command.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_src = 3'd2; cmd_dst = 3'd5;
        @(negedge clk);
        cmd_op = 2'd3; cmd_src = 3'd0; cmd_dst = 3'd1;
        check("busy valid s1", 64'(actual()),
              64'({mk(8'h20, 8'h04, 5'b00010), 2'b00, 6'h20, 2'b00, 6'h04, 6'b000100}));
        @(negedge clk);
        check("busy valid idle", 64'(actual()), 64'({IDLE_REC, IDLE_REC}));
        cmd_valid = 1'b0;
        @(negedge clk);
        check("busy valid idle2", 64'(actual()), 64'({IDLE_REC, IDLE_REC}));
        mreg[5] = mreg[2];
        check("busy valid regs", 64'(breg), 64'(mreg));

        // Reset arriving on the edge that ends SWAP step 2.
        n8 = model(8, 2'd1, 1, 4, e8);
        void'(model(6, 2'd1, 1, 4, e6));
        check("mid swap steps", 64'(n8), 64'd3);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_src = 3'd1; cmd_dst = 3'd4;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_src = 3'd7; cmd_dst = 3'd2;
        check("mid swap s1", 64'(actual()), 64'({e8[0 +: REC_W], e6[0 +: REC_W]}));
        @(negedge clk);
        cmd_op = 2'd2;
        check("mid swap s2", 64'(actual()), 64'({e8[REC_W +: REC_W], e6[REC_W +: REC_W]}));
        reset = 1'b0;
        @(negedge clk);
        check("mid swap reset", 64'(actual()), 64'({IDLE_REC, IDLE_REC}));
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("mid swap after", 64'(actual()), 64'({IDLE_REC, IDLE_REC}));
        end
        // The interrupted swap leaves partial register contents behind.
        mreg  = breg;
        tmp_v = 1'b0;

        // Randomized commands against the model.
        repeat (150) begin
            logic [1:0] op;
            int src, dst;
            op  = 2'($urandom_range(0, 3));
            src = int'($urandom_range(0, 7));
            dst = int'($urandom_range(0, 7));
            n8  = model(8, op, src, dst, e8);
            run_cmd(op, src, dst, n8, e8, $sformatf("rand op=%0d s=%0d d=%0d", op, src, dst));
        end

        @(negedge clk);
        check("queue drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
